mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Memory-port arbiter: muxes dcache, icache demand and icache prefetch onto one bus
// and steers returned tags back to the requester that owns them.
`ifndef SYS_XLEN
`define SYS_XLEN 32
`endif

module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int PF_MAX_OUT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           dc_cmd,
  input  logic [`SYS_XLEN-1:0] dc_addr,
  input  logic [63:0]          dc_data,
  input  logic [1:0]           ic_cmd,
  input  logic [`SYS_XLEN-1:0] ic_addr,
  input  logic [1:0]           pf_cmd,
  input  logic [`SYS_XLEN-1:0] pf_addr,
  output logic [1:0]           proc2mem_command,
  output logic [`SYS_XLEN-1:0] proc2mem_addr,
  output logic [63:0]          proc2mem_data,
  input  logic [3:0]           mem2proc_response,
  input  logic [3:0]           mem2proc_tag,
  input  logic [63:0]          mem2proc_data,
  output logic [3:0]           dc_response,
  output logic [3:0]           ic_response,
  output logic [3:0]           pf_response,
  output logic [3:0]           dc_tag,
  output logic [3:0]           ic_tag,
  output logic [3:0]           pf_tag,
  output logic [63:0]          mem_data_out,
  output logic                 pf_bus_priority,
  output logic                 arb_err
);

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam int         SW       = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DC   = 2'd1,
    OWN_IC   = 2'd2,
    OWN_PF   = 2'd3
  } owner_e;

  // Owner table: entry for tag i lives at bits [2*(i-1) +: 2], tags 1..15.
  logic [29:0]   owner_r;
  logic [29:0]   owner_nxt_s;
  logic [3:0]    pf_out_r;
  logic [SW-1:0] ic_starve_r;
  logic          arb_err_r;

  logic   dc_act_s, ic_act_s, pf_act_s, pf_elig_s, ic_force_s;
  logic   accept_s, alloc_s, tag_ret_s, pf_inc_s, pf_dec_s, ic_win_s;
  owner_e grant_s;
  owner_e ret_owner_s;

  // Request qualification and grant selection.
  always_comb begin
    dc_act_s   = (dc_cmd != BUS_NONE);
    ic_act_s   = (ic_cmd != BUS_NONE);
    pf_act_s   = (pf_cmd != BUS_NONE);
    pf_elig_s  = pf_act_s && (32'(pf_out_r) < PF_MAX_OUT);
    ic_force_s = ic_act_s && (32'(ic_starve_r) == STARVE_LIMIT);
    if (!rst) begin
      grant_s = OWN_NONE;
    end else if (ic_force_s) begin
      grant_s = OWN_IC;
    end else if (dc_act_s) begin
      grant_s = OWN_DC;
    end else if (ic_act_s) begin
      grant_s = OWN_IC;
    end else if (pf_elig_s) begin
      grant_s = OWN_PF;
    end else begin
      grant_s = OWN_NONE;
    end
  end

  // Memory-port mux and accept routing.
  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = {`SYS_XLEN{1'b0}};
    proc2mem_data    = 64'd0;
    case (grant_s)
      OWN_DC: begin
        proc2mem_command = dc_cmd;
        proc2mem_addr    = dc_addr;
        proc2mem_data    = dc_data;
      end
      OWN_IC: begin
        proc2mem_command = ic_cmd;
        proc2mem_addr    = ic_addr;
      end
      OWN_PF: begin
        proc2mem_command = pf_cmd;
        proc2mem_addr    = pf_addr;
      end
      default: begin
        proc2mem_command = BUS_NONE;
      end
    endcase
    dc_response     = (grant_s == OWN_DC) ? mem2proc_response : 4'd0;
    ic_response     = (grant_s == OWN_IC) ? mem2proc_response : 4'd0;
    pf_response     = (grant_s == OWN_PF) ? mem2proc_response : 4'd0;
    accept_s        = (grant_s != OWN_NONE) && (mem2proc_response != 4'd0);
    alloc_s         = accept_s && (proc2mem_command == BUS_LOAD);
    ic_win_s        = accept_s && (grant_s == OWN_IC);
    pf_inc_s        = alloc_s && (grant_s == OWN_PF);
    pf_bus_priority = rst && pf_act_s && (grant_s != OWN_PF);
    mem_data_out    = mem2proc_data;
    arb_err         = arb_err_r;
  end

  // Tag lookup, return steering and next owner table (allocation applied after clear).
  always_comb begin
    tag_ret_s   = rst && (mem2proc_tag != 4'd0);
    ret_owner_s = OWN_NONE;
    owner_nxt_s = owner_r;
    for (int i = 1; i < 16; i++) begin
      ret_owner_s = (mem2proc_tag == 4'(i)) ? owner_e'(owner_r[2*(i-1) +: 2]) : ret_owner_s;
      owner_nxt_s[2*(i-1) +: 2] = (tag_ret_s && (mem2proc_tag == 4'(i))) ? OWN_NONE
                                                                          : owner_nxt_s[2*(i-1) +: 2];
      owner_nxt_s[2*(i-1) +: 2] = (alloc_s && (mem2proc_response == 4'(i))) ? grant_s
                                                                             : owner_nxt_s[2*(i-1) +: 2];
    end
    pf_dec_s = tag_ret_s && (ret_owner_s == OWN_PF);
    dc_tag   = (tag_ret_s && (ret_owner_s == OWN_DC)) ? mem2proc_tag : 4'd0;
    ic_tag   = (tag_ret_s && (ret_owner_s == OWN_IC)) ? mem2proc_tag : 4'd0;
    pf_tag   = (tag_ret_s && (ret_owner_s == OWN_PF)) ? mem2proc_tag : 4'd0;
  end

  // Owner table, prefetch outstanding count, icache starvation and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_r     <= 30'd0;
      pf_out_r    <= 4'd0;
      ic_starve_r <= {SW{1'b0}};
      arb_err_r   <= 1'b0;
    end else begin
      owner_r <= owner_nxt_s;
      if (tag_ret_s && (ret_owner_s == OWN_NONE)) begin
        arb_err_r <= 1'b1;
      end else begin
        arb_err_r <= arb_err_r;
      end
      case ({pf_inc_s, pf_dec_s})
        2'b10: begin
          if (pf_out_r != 4'd15) pf_out_r <= pf_out_r + 4'd1;
          else pf_out_r <= pf_out_r;
        end
        2'b01: begin
          if (pf_out_r != 4'd0) pf_out_r <= pf_out_r - 4'd1;
          else pf_out_r <= pf_out_r;
        end
        default: pf_out_r <= pf_out_r;
      endcase
      if (!ic_act_s || ic_win_s) begin
        ic_starve_r <= {SW{1'b0}};
      end else if (32'(ic_starve_r) < STARVE_LIMIT) begin
        ic_starve_r <= ic_starve_r + SW'(1);
      end else begin
        ic_starve_r <= ic_starve_r;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scenario bench for mem_bus_arbiter: expected tag owners go into a scoreboard queue
// at accept time and are popped when the tag comes back.
`ifndef SYS_XLEN
`define SYS_XLEN 32
`endif

module tb_mem_bus_arbiter;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [1:0] W_NONE = 2'd0;
  localparam logic [1:0] W_DC   = 2'd1;
  localparam logic [1:0] W_IC   = 2'd2;
  localparam logic [1:0] W_PF   = 2'd3;

  logic                 clk;
  logic                 rst;
  logic [1:0]           dc_cmd, ic_cmd, pf_cmd;
  logic [`SYS_XLEN-1:0] dc_addr, ic_addr, pf_addr;
  logic [63:0]          dc_data;
  logic [1:0]           proc2mem_command;
  logic [`SYS_XLEN-1:0] proc2mem_addr;
  logic [63:0]          proc2mem_data;
  logic [3:0]           mem2proc_response, mem2proc_tag;
  logic [63:0]          mem2proc_data;
  logic [3:0]           dc_response, ic_response, pf_response;
  logic [3:0]           dc_tag, ic_tag, pf_tag;
  logic [63:0]          mem_data_out;
  logic                 pf_bus_priority, arb_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] tag;
    logic [1:0] who;
  } sb_t;
  sb_t sb_q[$];

  mem_bus_arbiter #(.STARVE_LIMIT(4), .PF_MAX_OUT(4)) dut (
    .clk(clk), .rst(rst),
    .dc_cmd(dc_cmd), .dc_addr(dc_addr), .dc_data(dc_data),
    .ic_cmd(ic_cmd), .ic_addr(ic_addr),
    .pf_cmd(pf_cmd), .pf_addr(pf_addr),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag),
    .mem2proc_data(mem2proc_data),
    .dc_response(dc_response), .ic_response(ic_response), .pf_response(pf_response),
    .dc_tag(dc_tag), .ic_tag(ic_tag), .pf_tag(pf_tag),
    .mem_data_out(mem_data_out), .pf_bus_priority(pf_bus_priority), .arb_err(arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dc_cmd = BUS_NONE; ic_cmd = BUS_NONE; pf_cmd = BUS_NONE;
    dc_addr = 32'd0; ic_addr = 32'd0; pf_addr = 32'd0; dc_data = 64'd0;
    mem2proc_response = 4'd0; mem2proc_tag = 4'd0;
    mem2proc_data = {$urandom(), $urandom()};
  endtask

  task automatic sb_push(input logic [3:0] tag, input logic [1:0] who);
    sb_t e;
    e.tag = tag;
    e.who = who;
    sb_q.push_back(e);
  endtask

  task automatic sb_take(input logic [3:0] tag, output logic [1:0] who);
    who = W_NONE;
    for (int i = 0; i < sb_q.size(); i++) begin
      if (sb_q[i].tag == tag) begin
        who = sb_q[i].who;
        sb_q.delete(i);
        break;
      end
    end
  endtask

  function automatic logic [11:0] exp_tags(input logic [3:0] t, input logic [1:0] who);
    return {(who == W_DC) ? t : 4'd0, (who == W_IC) ? t : 4'd0, (who == W_PF) ? t : 4'd0};
  endfunction

  task automatic test_reset();
    idle();
    rst = 1'b0;
    dc_cmd = BUS_LOAD; ic_cmd = BUS_LOAD; pf_cmd = BUS_LOAD;
    mem2proc_response = 4'd5; mem2proc_tag = 4'd5; mem2proc_data = 64'hDEAD_BEEF_0123_4567;
    #1;
    n_cmp++;
    if (proc2mem_command !== BUS_NONE) begin
      n_err++; $display("FAIL rst_cmd: got %0d want %0d", proc2mem_command, BUS_NONE);
    end
    n_cmp++;
    if ({dc_response, ic_response, pf_response, dc_tag, ic_tag, pf_tag} !== 24'd0) begin
      n_err++; $display("FAIL rst_resp_tag: got %h want 0",
                        {dc_response, ic_response, pf_response, dc_tag, ic_tag, pf_tag});
    end
    tick();
    n_cmp++;
    if ({arb_err, dut.pf_out_r, dut.ic_starve_r, dut.owner_r} !== 38'd0) begin
      n_err++; $display("FAIL rst_state: err=%b pf_out=%0d starve=%0d owner=%h want all 0",
                        arb_err, dut.pf_out_r, dut.ic_starve_r, dut.owner_r);
    end
    n_cmp++;
    if (mem_data_out !== 64'hDEAD_BEEF_0123_4567) begin
      n_err++; $display("FAIL rst_data_pass: got %h want %h", mem_data_out, 64'hDEAD_BEEF_0123_4567);
    end
    idle();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_priority();
    logic [1:0] who;
    idle();
    dc_cmd = BUS_LOAD; dc_addr = 32'h0000_1000; dc_data = 64'hAAAA_5555_1234_0001;
    ic_cmd = BUS_LOAD; ic_addr = 32'h0000_2000; mem2proc_response = 4'd3;
    #1;
    n_cmp++;
    if ({proc2mem_command, proc2mem_addr, proc2mem_data} !== {BUS_LOAD, 32'h0000_1000, 64'hAAAA_5555_1234_0001}) begin
      n_err++; $display("FAIL prio_bus: got cmd=%0d addr=%h data=%h want dc request",
                        proc2mem_command, proc2mem_addr, proc2mem_data);
    end
    n_cmp++;
    if ({dc_response, ic_response, pf_response} !== {4'd3, 4'd0, 4'd0}) begin
      n_err++; $display("FAIL prio_resp: got dc=%0d ic=%0d pf=%0d want 3/0/0", dc_response, ic_response, pf_response);
    end
    sb_push(4'd3, W_DC);
    tick();
    idle(); mem2proc_tag = 4'd3;
    #1;
    sb_take(4'd3, who);
    n_cmp++;
    if ({dc_tag, ic_tag, pf_tag} !== exp_tags(4'd3, who)) begin
      n_err++; $display("FAIL prio_tag3: got %h want %h", {dc_tag, ic_tag, pf_tag}, exp_tags(4'd3, who));
    end
    n_cmp++;
    if (mem_data_out !== mem2proc_data) begin
      n_err++; $display("FAIL data_pass: got %h want %h", mem_data_out, mem2proc_data);
    end
    tick();
    idle(); ic_cmd = BUS_LOAD; ic_addr = 32'h0000_2040; mem2proc_response = 4'd4;
    #1;
    n_cmp++;
    if ({proc2mem_command, proc2mem_addr, proc2mem_data, ic_response} !== {BUS_LOAD, 32'h0000_2040, 64'd0, 4'd4}) begin
      n_err++; $display("FAIL ic_alone: got cmd=%0d addr=%h data=%h resp=%0d want 1/2040/0/4",
                        proc2mem_command, proc2mem_addr, proc2mem_data, ic_response);
    end
    sb_push(4'd4, W_IC);
    tick();
    idle(); pf_cmd = BUS_LOAD; pf_addr = 32'h0000_3000; mem2proc_tag = 4'd4;
    #1;
    sb_take(4'd4, who);
    n_cmp++;
    if ({proc2mem_addr, pf_response, pf_bus_priority} !== {32'h0000_3000, 4'd0, 1'b0}) begin
      n_err++; $display("FAIL pf_reject: got addr=%h resp=%0d prio=%b want 3000/0/0",
                        proc2mem_addr, pf_response, pf_bus_priority);
    end
    n_cmp++;
    if ({dc_tag, ic_tag, pf_tag} !== exp_tags(4'd4, who)) begin
      n_err++; $display("FAIL ic_tag4: got %h want %h", {dc_tag, ic_tag, pf_tag}, exp_tags(4'd4, who));
    end
    tick();
    idle();
  endtask

  task automatic test_starve();
    logic [1:0] who;
    for (int c = 0; c < 4; c++) begin
      idle();
      dc_cmd = BUS_STORE; dc_addr = 32'h0000_4000 + 32'(c); dc_data = 64'(c);
      ic_cmd = BUS_LOAD; ic_addr = 32'h0000_5000;
      #1;
      n_cmp++;
      if ({proc2mem_addr, ic_response} !== {32'h0000_4000 + 32'(c), 4'd0}) begin
        n_err++; $display("FAIL starve_dc_win%0d: got addr=%h ic_resp=%0d want %h/0",
                          c, proc2mem_addr, ic_response, 32'h0000_4000 + 32'(c));
      end
      tick();
    end
    n_cmp++;
    if (dut.ic_starve_r !== 3'd4) begin
      n_err++; $display("FAIL starve_count: got %0d want 4", dut.ic_starve_r);
    end
    mem2proc_response = 4'd6;
    #1;
    n_cmp++;
    if ({proc2mem_command, proc2mem_addr, proc2mem_data, ic_response, dc_response} !==
        {BUS_LOAD, 32'h0000_5000, 64'd0, 4'd6, 4'd0}) begin
      n_err++; $display("FAIL starve_force: got cmd=%0d addr=%h ic_resp=%0d dc_resp=%0d want ic granted with 6",
                        proc2mem_command, proc2mem_addr, ic_response, dc_response);
    end
    sb_push(4'd6, W_IC);
    tick();
    idle(); mem2proc_tag = 4'd6;
    #1;
    n_cmp++;
    if (dut.ic_starve_r !== 3'd0) begin
      n_err++; $display("FAIL starve_clear: got %0d want 0", dut.ic_starve_r);
    end
    sb_take(4'd6, who);
    n_cmp++;
    if ({dc_tag, ic_tag, pf_tag} !== exp_tags(4'd6, who)) begin
      n_err++; $display("FAIL starve_tag6: got %h want %h", {dc_tag, ic_tag, pf_tag}, exp_tags(4'd6, who));
    end
    tick();
    idle();
  endtask

  task automatic test_pf_cap();
    logic [1:0] who;
    for (int i = 1; i <= 4; i++) begin
      idle(); pf_cmd = BUS_LOAD; pf_addr = 32'h0000_6000 + 32'(i); mem2proc_response = 4'(i);
      #1;
      n_cmp++;
      if ({proc2mem_addr, pf_response} !== {32'h0000_6000 + 32'(i), 4'(i)}) begin
        n_err++; $display("FAIL pf_load%0d: got addr=%h resp=%0d", i, proc2mem_addr, pf_response);
      end
      sb_push(4'(i), W_PF);
      tick();
    end
    idle(); pf_cmd = BUS_LOAD; pf_addr = 32'h0000_6100; mem2proc_response = 4'd9;
    #1;
    n_cmp++;
    if ({proc2mem_command, pf_response, pf_bus_priority} !== {BUS_NONE, 4'd0, 1'b1}) begin
      n_err++; $display("FAIL pf_capped: got cmd=%0d resp=%0d prio=%b want 0/0/1",
                        proc2mem_command, pf_response, pf_bus_priority);
    end
    tick();
    idle(); pf_cmd = BUS_LOAD; pf_addr = 32'h0000_6100; mem2proc_tag = 4'd2;
    #1;
    sb_take(4'd2, who);
    n_cmp++;
    if ({dc_tag, ic_tag, pf_tag, pf_bus_priority} !== {exp_tags(4'd2, who), 1'b1}) begin
      n_err++; $display("FAIL pf_ret2: got tags=%h prio=%b want %h/1",
                        {dc_tag, ic_tag, pf_tag}, pf_bus_priority, exp_tags(4'd2, who));
    end
    tick();
    idle(); pf_cmd = BUS_LOAD; pf_addr = 32'h0000_6200; mem2proc_response = 4'd5;
    #1;
    n_cmp++;
    if ({proc2mem_command, proc2mem_addr, pf_response, pf_bus_priority} !== {BUS_LOAD, 32'h0000_6200, 4'd5, 1'b0}) begin
      n_err++; $display("FAIL pf_uncapped: got cmd=%0d addr=%h resp=%0d prio=%b want 1/6200/5/0",
                        proc2mem_command, proc2mem_addr, pf_response, pf_bus_priority);
    end
    sb_push(4'd5, W_PF);
    tick();
    for (int k = 0; k < 3; k++) begin
      logic [3:0] t;
      t = (k == 0) ? 4'd1 : ((k == 1) ? 4'd3 : 4'd4);
      idle(); mem2proc_tag = t;
      #1;
      sb_take(t, who);
      n_cmp++;
      if ({dc_tag, ic_tag, pf_tag} !== exp_tags(t, who)) begin
        n_err++; $display("FAIL pf_ret%0d: got %h want %h", t, {dc_tag, ic_tag, pf_tag}, exp_tags(t, who));
      end
      tick();
    end
    n_cmp++;
    if (dut.pf_out_r !== 4'd1) begin
      n_err++; $display("FAIL pf_count: got %0d want 1", dut.pf_out_r);
    end
    idle();
  endtask

  task automatic test_same_cycle();
    logic [1:0] who;
    idle(); pf_cmd = BUS_LOAD; pf_addr = 32'h0000_6300; mem2proc_response = 4'd5; mem2proc_tag = 4'd5;
    #1;
    sb_take(4'd5, who);
    n_cmp++;
    if ({dc_tag, ic_tag, pf_tag, pf_response} !== {exp_tags(4'd5, who), 4'd5}) begin
      n_err++; $display("FAIL same_cycle: got tags=%h resp=%0d want %h/5",
                        {dc_tag, ic_tag, pf_tag}, pf_response, exp_tags(4'd5, who));
    end
    sb_push(4'd5, W_PF);
    tick();
    idle(); mem2proc_tag = 4'd5;
    #1;
    n_cmp++;
    if (dut.pf_out_r !== 4'd1) begin
      n_err++; $display("FAIL same_cycle_count: got %0d want 1", dut.pf_out_r);
    end
    sb_take(4'd5, who);
    n_cmp++;
    if ({dc_tag, ic_tag, pf_tag} !== exp_tags(4'd5, who)) begin
      n_err++; $display("FAIL same_cycle_realloc: got %h want %h", {dc_tag, ic_tag, pf_tag}, exp_tags(4'd5, who));
    end
    tick();
    idle();
  endtask

  task automatic test_store_err();
    logic [1:0] who;
    idle(); dc_cmd = BUS_STORE; dc_addr = 32'h0000_7000; dc_data = 64'h7777; mem2proc_response = 4'd7;
    #1;
    n_cmp++;
    if ({proc2mem_command, dc_response} !== {BUS_STORE, 4'd7}) begin
      n_err++; $display("FAIL store_accept: got cmd=%0d resp=%0d want 2/7", proc2mem_command, dc_response);
    end
    tick();
    idle(); mem2proc_tag = 4'd7;
    #1;
    sb_take(4'd7, who);
    n_cmp++;
    if ({dc_tag, ic_tag, pf_tag, arb_err} !== {exp_tags(4'd7, who), 1'b0}) begin
      n_err++; $display("FAIL store_ret: got tags=%h err=%b want %h/0",
                        {dc_tag, ic_tag, pf_tag}, arb_err, exp_tags(4'd7, who));
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (arb_err !== 1'b1) begin
      n_err++; $display("FAIL err_set: got %b want 1", arb_err);
    end
    tick();
    n_cmp++;
    if (arb_err !== 1'b1) begin
      n_err++; $display("FAIL err_sticky: got %b want 1", arb_err);
    end
  endtask

  task automatic test_reset_midflight();
    logic [1:0] who;
    idle(); ic_cmd = BUS_LOAD; ic_addr = 32'h0000_8000; mem2proc_response = 4'd2;
    #1; sb_push(4'd2, W_IC);
    tick();
    idle(); pf_cmd = BUS_LOAD; pf_addr = 32'h0000_8100; mem2proc_response = 4'd3;
    #1; sb_push(4'd3, W_PF);
    tick();
    idle(); dc_cmd = BUS_LOAD; dc_addr = 32'h0000_8200; ic_cmd = BUS_LOAD; mem2proc_response = 4'd1;
    #1; sb_push(4'd1, W_DC);
    tick();
    idle();
    n_cmp++;
    if ({dut.pf_out_r, dut.ic_starve_r, arb_err} !== {4'd1, 3'd1, 1'b1}) begin
      n_err++; $display("FAIL pre_reset: got pf_out=%0d starve=%0d err=%b want 1/1/1",
                        dut.pf_out_r, dut.ic_starve_r, arb_err);
    end
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({arb_err, dut.pf_out_r, dut.ic_starve_r, dut.owner_r} !== 38'd0) begin
      n_err++; $display("FAIL async_reset: err=%b pf_out=%0d starve=%0d owner=%h want all 0",
                        arb_err, dut.pf_out_r, dut.ic_starve_r, dut.owner_r);
    end
    sb_q.delete();
    tick();
    rst = 1'b1;
    tick();
    idle(); mem2proc_tag = 4'd2;
    #1;
    sb_take(4'd2, who);
    n_cmp++;
    if ({dc_tag, ic_tag, pf_tag} !== exp_tags(4'd2, who)) begin
      n_err++; $display("FAIL dropped_tag: got %h want %h", {dc_tag, ic_tag, pf_tag}, exp_tags(4'd2, who));
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (arb_err !== 1'b1) begin
      n_err++; $display("FAIL dropped_err: got %b want 1", arb_err);
    end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_priority();
    test_starve();
    test_pf_cap();
    test_same_cycle();
    test_store_err();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
